// File: rtl/fpu_pkg.sv
// Shared binary32 constants, the unpacked-operand record and the unpack helper
// used by the FPU datapath units.
package fpu_pkg;

    localparam logic signed [9:0] EXP_BIAS = 10'sd127;
    localparam logic signed [9:0] EXP_MAX  = 10'sd128;
    localparam logic signed [9:0] EXP_MIN  = -10'sd126;
    localparam logic signed [9:0] EXP_ZERO = -10'sd127;

    localparam logic [31:0] QNAN_DEFAULT = 32'hFFC0_0000;
    localparam logic [31:0] POS_INF      = 32'h7F80_0000;
    localparam logic [31:0] QUIET_BIT    = 32'h0040_0000;

    localparam int          DIV_STEPS = 27;
    localparam logic [4:0]  DIV_LAST  = 5'(DIV_STEPS - 1);

    typedef struct packed {
        logic        sign;
        logic [9:0]  exp;
        logic [23:0] man;
    } fp_unpacked_t;

    // Exponent is unbiased two's complement; the hidden bit is added later.
    function automatic fp_unpacked_t unpackOperand(input logic [31:0] v);
        fp_unpacked_t u;
        u.sign = v[31];
        u.exp  = {2'b00, v[30:23]} - EXP_BIAS;
        u.man  = {1'b0, v[22:0]};
        return u;
    endfunction

endpackage

// File: rtl/fpu_div_if.sv
// Operand/result handshake shared by the FPU arithmetic units.
interface fpu_div_if;

    logic [31:0] din1;
    logic [31:0] din2;
    logic        valid;
    logic [31:0] result;
    logic        ready;

    modport master (output din1, din2, valid, input result, ready);
    modport slave  (input din1, din2, valid, output result, ready);

endinterface

// File: rtl/fpu_div_iter.sv
// Restoring mantissa divider: 27 iterations yield floor(a*2^26/b).
// o_done is high during the final iteration; o_quot/o_remNz are valid the cycle after.
module fpu_div_iter
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic [23:0] i_aMan,
    input  logic [23:0] i_bMan,
    output logic        o_done,
    output logic [26:0] o_quot,
    output logic        o_remNz
);

    logic [25:0] r_rem;
    logic [26:0] r_quot;
    logic [4:0]  r_count;
    logic        r_busy;

    logic        w_ge;
    logic [25:0] w_diff;

    always_comb begin
        w_ge   = r_rem >= {2'b00, i_bMan};
        w_diff = w_ge ? (r_rem - {2'b00, i_bMan}) : r_rem;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rem   <= '0;
            r_quot  <= '0;
            r_count <= '0;
            r_busy  <= 1'b0;
        end else if (i_start) begin
            r_rem   <= {2'b00, i_aMan};
            r_quot  <= '0;
            r_count <= '0;
            r_busy  <= 1'b1;
        end else if (r_busy) begin
            r_rem   <= w_diff << 1;
            r_quot  <= {r_quot[25:0], w_ge};
            r_count <= r_count + 5'd1;
            if (r_count == DIV_LAST) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_done  = r_busy && (r_count == DIV_LAST);
    assign o_quot  = r_quot;
    assign o_remNz = (r_rem != '0);

endmodule

// File: rtl/fpu_div.sv
// Multi-cycle IEEE-754 binary32 divider with round-to-nearest-even,
// sharing the valid/ready handshake and special-value rules of fpu_mul.
module fpu_div
    import fpu_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    fpu_div_if.slave  bus
);

    typedef enum logic [3:0] {
        WAIT, UNPACK, SPECIAL, NORM_A, NORM_B, DIV_INIT, DIVIDE,
        SET_GRS, NORM_1, NORM_2, ROUND, PACK, READY
    } state_t;

    state_t       r_state, w_nextState;

    logic [31:0]  r_a, r_b, r_z, r_result;
    fp_unpacked_t r_aOp, r_bOp;
    logic         r_zSign, r_guard, r_round, r_sticky, r_ready;
    logic [9:0]   r_zExp;
    logic [23:0]  r_zMan;

    logic         w_aNan, w_bNan, w_aInf, w_bInf, w_aZero, w_bZero, w_isSpecial;
    logic         w_divStart, w_divDone, w_remNz, w_sgn;
    logic [26:0]  w_quot;
    logic [7:0]   w_biasedExp;
    logic [31:0]  w_packed;

    fpu_div_iter u_iter (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_divStart),
        .i_aMan  (r_aOp.man),
        .i_bMan  (r_bOp.man),
        .o_done  (w_divDone),
        .o_quot  (w_quot),
        .o_remNz (w_remNz)
    );

    always_comb begin
        w_aNan      = (r_aOp.exp == EXP_MAX)  && (r_aOp.man != '0);
        w_bNan      = (r_bOp.exp == EXP_MAX)  && (r_bOp.man != '0);
        w_aInf      = (r_aOp.exp == EXP_MAX)  && (r_aOp.man == '0);
        w_bInf      = (r_bOp.exp == EXP_MAX)  && (r_bOp.man == '0);
        w_aZero     = (r_aOp.exp == EXP_ZERO) && (r_aOp.man == '0);
        w_bZero     = (r_bOp.exp == EXP_ZERO) && (r_bOp.man == '0);
        w_isSpecial = w_aNan | w_bNan | w_aInf | w_bInf | w_aZero | w_bZero;
        w_sgn       = r_aOp.sign ^ r_bOp.sign;
    end

    // Exponent field collapses to 0 for denormals; anything above +127 saturates to inf.
    always_comb begin
        w_biasedExp = r_zExp[7:0] + EXP_BIAS[7:0];
        w_packed    = {r_zSign, w_biasedExp, r_zMan[22:0]};
        if ((r_zExp == EXP_MIN) && !r_zMan[23]) begin
            w_packed[30:23] = 8'h00;
        end
        if ($signed(r_zExp) > EXP_BIAS) begin
            w_packed = {r_zSign, POS_INF[30:0]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= WAIT;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_divStart  = 1'b0;
        case (r_state)
            WAIT:     if (bus.valid) w_nextState = UNPACK;
            UNPACK:   w_nextState = SPECIAL;
            SPECIAL:  w_nextState = w_isSpecial ? READY : NORM_A;
            NORM_A:   if (r_aOp.man[23]) w_nextState = NORM_B;
            NORM_B:   if (r_bOp.man[23]) w_nextState = DIV_INIT;
            DIV_INIT: begin
                w_divStart  = 1'b1;
                w_nextState = DIVIDE;
            end
            DIVIDE:   if (w_divDone) w_nextState = SET_GRS;
            SET_GRS:  w_nextState = NORM_1;
            NORM_1:   if (r_zMan[23]) w_nextState = NORM_2;
            NORM_2:   if (!($signed(r_zExp) < EXP_MIN)) w_nextState = ROUND;
            ROUND:    w_nextState = PACK;
            PACK:     w_nextState = READY;
            READY:    w_nextState = WAIT;
            default:  w_nextState = WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_aOp    <= '0;
            r_bOp    <= '0;
            r_z      <= '0;
            r_zSign  <= 1'b0;
            r_zExp   <= '0;
            r_zMan   <= '0;
            r_guard  <= 1'b0;
            r_round  <= 1'b0;
            r_sticky <= 1'b0;
            r_result <= '0;
            r_ready  <= 1'b0;
        end else begin
            case (r_state)
                WAIT: begin
                    r_ready <= 1'b0;
                    if (bus.valid) begin
                        r_a <= bus.din1;
                        r_b <= bus.din2;
                    end
                end
                UNPACK: begin
                    r_aOp <= unpackOperand(r_a);
                    r_bOp <= unpackOperand(r_b);
                end
                SPECIAL: begin
                    if (w_aNan)                             r_z <= r_a | QUIET_BIT;
                    else if (w_bNan)                        r_z <= r_b | QUIET_BIT;
                    else if ((w_aInf && w_bInf) || (w_aZero && w_bZero)) r_z <= QNAN_DEFAULT;
                    else if (w_aInf)                        r_z <= {w_sgn, POS_INF[30:0]};
                    else if (w_bInf)                        r_z <= {w_sgn, 31'd0};
                    else if (w_bZero)                       r_z <= {w_sgn, POS_INF[30:0]};
                    else if (w_aZero)                       r_z <= {w_sgn, 31'd0};
                    else begin
                        if (r_aOp.exp == EXP_ZERO) r_aOp.exp <= EXP_MIN;
                        else                       r_aOp.man[23] <= 1'b1;
                        if (r_bOp.exp == EXP_ZERO) r_bOp.exp <= EXP_MIN;
                        else                       r_bOp.man[23] <= 1'b1;
                    end
                end
                NORM_A: if (!r_aOp.man[23]) begin
                    r_aOp.man <= r_aOp.man << 1;
                    r_aOp.exp <= r_aOp.exp - 10'd1;
                end
                NORM_B: if (!r_bOp.man[23]) begin
                    r_bOp.man <= r_bOp.man << 1;
                    r_bOp.exp <= r_bOp.exp - 10'd1;
                end
                DIV_INIT: begin
                    r_zSign <= w_sgn;
                    r_zExp  <= r_aOp.exp - r_bOp.exp;
                end
                SET_GRS: begin
                    r_zMan   <= w_quot[26:3];
                    r_guard  <= w_quot[2];
                    r_round  <= w_quot[1];
                    r_sticky <= w_quot[0] | w_remNz;
                end
                NORM_1: if (!r_zMan[23]) begin
                    r_zMan  <= {r_zMan[22:0], r_guard};
                    r_guard <= r_round;
                    r_round <= 1'b0;
                    r_zExp  <= r_zExp - 10'd1;
                end
                // Denormalise: bits leaving the mantissa feed guard, round, then sticky.
                NORM_2: if ($signed(r_zExp) < EXP_MIN) begin
                    r_zMan   <= r_zMan >> 1;
                    r_guard  <= r_zMan[0];
                    r_round  <= r_guard;
                    r_sticky <= r_sticky | r_round;
                    r_zExp   <= r_zExp + 10'd1;
                end
                ROUND: if (r_guard && (r_round || r_sticky || r_zMan[0])) begin
                    r_zMan <= r_zMan + 24'd1;
                    if (r_zMan == 24'hFF_FFFF) begin
                        r_zExp <= r_zExp + 10'd1;
                    end
                end
                PACK: r_z <= w_packed;
                READY: begin
                    r_result <= r_z;
                    r_ready  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.result = r_result;
    assign bus.ready  = r_ready;

endmodule
